// File: rtl/freq_window_sequencer.sv
// Gated edge counter: counts edge_pulse over a programmable window of clk cycles,
// then holds the result under a valid/ready handshake before the next window.
module freq_window_sequencer #(
  parameter int unsigned UPDATE_PERIOD = 1199,
  parameter int unsigned BITS          = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            edge_pulse,
  input  logic [BITS-1:0] period,
  input  logic            period_load,
  input  logic            result_ready,
  output logic            result_valid,
  output logic [6:0]      result_count,
  output logic            overflow,
  output logic [1:0]      state,
  output logic [BITS-1:0] clk_count
);

  localparam logic [BITS-1:0] INIT_PERIOD = BITS'(UPDATE_PERIOD);
  localparam logic [6:0]      EDGE_MAX    = 7'd127;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COUNT   = 2'b01,
    PRESENT = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] period_q;
  logic [BITS-1:0] active_q, active_d;
  logic [BITS-1:0] count_q, count_d;
  logic [6:0]      edges_q, edges_d;
  logic            flag_q, flag_d;
  logic            valid_q, valid_d;
  logic [6:0]      result_q, result_d;
  logic            res_ovf_q, res_ovf_d;

  logic [BITS-1:0] start_period;
  logic [6:0]      edges_next;
  logic            flag_next;

  // A write in the same cycle as a window start must land in that window.
  assign start_period = period_load ? period : period_q;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    count_d    = count_q;
    edges_d    = edges_q;
    flag_d     = flag_q;
    valid_d    = valid_q;
    result_d   = result_q;
    res_ovf_d  = res_ovf_q;
    edges_next = edges_q;
    flag_next  = flag_q;

    if (edge_pulse) begin
      if (edges_q == EDGE_MAX) flag_next = 1'b1;
      else                     edges_next = edges_q + 7'd1;
    end

    case (state_q)
      IDLE: begin
        count_d = '0;
        edges_d = '0;
        flag_d  = 1'b0;
        if (enable) begin
          state_d  = COUNT;
          active_d = start_period;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
          edges_d = '0;
          flag_d  = 1'b0;
        end else if (count_q == active_q) begin
          // Last window cycle: its edge is folded into the published result.
          state_d   = PRESENT;
          result_d  = edges_next;
          res_ovf_d = flag_next;
          valid_d   = 1'b1;
          count_d   = '0;
          edges_d   = '0;
          flag_d    = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
          edges_d = edges_next;
          flag_d  = flag_next;
        end
      end
      PRESENT: begin
        count_d = '0;
        edges_d = '0;
        flag_d  = 1'b0;
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          if (enable) begin
            state_d  = COUNT;
            active_d = start_period;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        edges_d = '0;
        flag_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      period_q  <= INIT_PERIOD;
      active_q  <= INIT_PERIOD;
      count_q   <= '0;
      edges_q   <= '0;
      flag_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      count_q   <= count_d;
      edges_q   <= edges_d;
      flag_q    <= flag_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      res_ovf_q <= res_ovf_d;
      if (period_load) period_q <= period;
    end
  end

  assign state        = state_q;
  assign clk_count    = count_q;
  assign result_valid = valid_q;
  assign result_count = result_q;
  assign overflow     = res_ovf_q;

endmodule

// File: tb/tb_freq_window_sequencer.sv
// Directed bench for freq_window_sequencer: a per-cycle vector table for the
// basic window, then hand sequences for saturation, stall, period reload, abort and reset.
module tb_freq_window_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        edge_pulse;
  logic [11:0] period;
  logic        period_load;
  logic        result_ready;
  logic        result_valid;
  logic [6:0]  result_count;
  logic        overflow;
  logic [1:0]  state;
  logic [11:0] clk_count;

  int checks = 0;
  int errors = 0;

  freq_window_sequencer #(.UPDATE_PERIOD(9), .BITS(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_load  (period_load),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .result_count (result_count),
    .overflow     (overflow),
    .state        (state),
    .clk_count    (clk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ep;
    logic        rdy;
    logic [1:0]  st;
    logic [11:0] cc;
    logic        vld;
    logic [6:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic [11:0] cc,
                            input logic vld, input logic [6:0] cnt, input logic ovf);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".clk_count"}, 32'(clk_count), 32'(cc));
    check({tag, ".valid"}, 32'(result_valid), 32'(vld));
    check({tag, ".count"}, 32'(result_count), 32'(cnt));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; edge_pulse = 1'b0;
    period = '0; period_load = 1'b0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  // Starts with a window observed at clk_count 0; returns its length in COUNT cycles.
  task automatic run_window(input int load_at, input logic [11:0] load_val, output int len);
    len = 1;
    for (int i = 0; i < 300; i++) begin
      period_load = (load_at >= 0) && (clk_count == 12'(load_at));
      period      = load_val;
      step();
      period_load = 1'b0;
      if (result_valid) return;
      len++;
    end
    check("window_timeout", 32'(len), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 12'd0, 1'b0, 7'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd1, 1'b0, 7'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'd1, 12'd2, 1'b0, 7'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd3, 1'b0, 7'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd1, 12'd4, 1'b0, 7'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd5, 1'b0, 7'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 12'd6, 1'b0, 7'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd7, 1'b0, 7'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 12'd8, 1'b0, 7'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd9, 1'b0, 7'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 12'd0, 1'b1, 7'd5, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd0, 1'b0, 7'd5, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 12'd1, 1'b0, 7'd5, 1'b0};

    do_reset();
    check_outs("reset", 2'd0, 12'd0, 1'b0, 7'd0, 1'b0);

    // Default period 9, edge every other cycle.
    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; edge_pulse = tbl[i].ep; result_ready = tbl[i].rdy;
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].cc, tbl[i].vld, tbl[i].cnt, tbl[i].ovf);
    end

    // Saturation over a 200-cycle window, then a clean 3-edge window.
    do_reset();
    enable = 1'b1; period = 12'd199; period_load = 1'b1; edge_pulse = 1'b0;
    step();
    check_outs("sat_start", 2'd1, 12'd0, 1'b0, 7'd0, 1'b0);
    period_load = 1'b0; edge_pulse = 1'b1;
    repeat (199) step();
    check_outs("sat_last", 2'd1, 12'd199, 1'b0, 7'd0, 1'b0);
    step();
    check_outs("sat_done", 2'd2, 12'd0, 1'b1, 7'd127, 1'b1);
    edge_pulse = 1'b0; result_ready = 1'b1;
    step();
    check_outs("sat_next", 2'd1, 12'd0, 1'b0, 7'd127, 1'b1);
    result_ready = 1'b0; edge_pulse = 1'b1;
    repeat (3) step();
    edge_pulse = 1'b0;
    repeat (196) step();
    check_outs("three_last", 2'd1, 12'd199, 1'b0, 7'd127, 1'b1);
    step();
    check_outs("three_done", 2'd2, 12'd0, 1'b1, 7'd3, 1'b0);

    // Downstream stall: result held, edges ignored.
    for (int i = 0; i < 20; i++) begin
      edge_pulse = i[0];
      step();
      check_outs($sformatf("stall%0d", i), 2'd2, 12'd0, 1'b1, 7'd3, 1'b0);
    end
    result_ready = 1'b1; edge_pulse = 1'b0;
    step();
    check_outs("stall_release", 2'd1, 12'd0, 1'b0, 7'd3, 1'b0);
    step();
    check("stall_cc1", 32'(clk_count), 32'd1);

    // Period written mid-window applies only from the following window.
    do_reset();
    enable = 1'b1; result_ready = 1'b1;
    step();
    check("reload_start", 32'(state), 32'd1);
    run_window(3, 12'd4, len);
    check("reload_len_cur", 32'(len), 32'd10);
    step();
    check("reload_next_start", 32'(clk_count), 32'd0);
    run_window(-1, 12'd0, len);
    check("reload_len_next", 32'(len), 32'd5);

    // Period 0 written in the handshake cycle: 1-cycle windows.
    period = 12'd0; period_load = 1'b1;
    step();
    check_outs("p0_start", 2'd1, 12'd0, 1'b0, 7'd0, 1'b0);
    period_load = 1'b0; edge_pulse = 1'b1;
    step();
    check_outs("p0_one", 2'd2, 12'd0, 1'b1, 7'd1, 1'b0);
    edge_pulse = 1'b0;
    step();
    check("p0_restart", 32'(state), 32'd1);
    step();
    check_outs("p0_zero", 2'd2, 12'd0, 1'b1, 7'd0, 1'b0);
    edge_pulse = 1'b1;
    step();
    step();
    check_outs("p0_again", 2'd2, 12'd0, 1'b1, 7'd1, 1'b0);

    // Abort at clk_count 3 keeps the previous result and raises no valid.
    period = 12'd9; period_load = 1'b1; edge_pulse = 1'b0;
    step();
    period_load = 1'b0; edge_pulse = 1'b1;
    repeat (3) step();
    check("abort_cc3", 32'(clk_count), 32'd3);
    enable = 1'b0;
    step();
    check_outs("abort", 2'd0, 12'd0, 1'b0, 7'd1, 1'b0);
    repeat (3) step();
    check_outs("idle_edges", 2'd0, 12'd0, 1'b0, 7'd1, 1'b0);

    // Asynchronous reset mid-window.
    enable = 1'b1; edge_pulse = 1'b0;
    repeat (3) step();
    check("pre_reset_cc", 32'(clk_count), 32'd2);
    #2 reset = 1'b0;
    #1;
    check_outs("async_reset", 2'd0, 12'd0, 1'b0, 7'd0, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step();
    check_outs("post_reset_idle", 2'd0, 12'd0, 1'b0, 7'd0, 1'b0);
    enable = 1'b1;
    step();
    check_outs("post_reset_start", 2'd1, 12'd0, 1'b0, 7'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_window_sequencer.md
FREQ_WINDOW_SEQUENCER -- requirements
Module: freq_window_sequencer

Interface
REQ-001 SHALL have parameter UPDATE_PERIOD, default 1199, the reset value of the window-length register (window = value+1 clk cycles).
REQ-002 SHALL have parameter BITS, default 12, the width of the period and clock-counter paths.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, high to run measurement windows.
REQ-006 SHALL have port edge_pulse, input, 1, one-cycle pulse per rising edge of the measured signal, synchronous to clk.
REQ-007 SHALL have port period, input, BITS, new window-length value.
REQ-008 SHALL have port period_load, input, 1, single-cycle write strobe for period.
REQ-009 SHALL have port result_ready, input, 1, downstream (display) accepts the result.
REQ-010 SHALL have port result_valid, output, 1, result_count holds a completed window.
REQ-011 SHALL have port result_count, output, 7, edges counted in the completed window.
REQ-012 SHALL have port overflow, output, 1, completed window saturated the edge count.
REQ-013 SHALL have port state, output, 2, current FSM state for debug.
REQ-014 SHALL have port clk_count, output, BITS, current window clock counter for debug.

Function
REQ-015 SHALL implement FSM states IDLE=2'b00, COUNT=2'b01, PRESENT=2'b10; 2'b11 unreachable and SHALL recover to IDLE next cycle.
REQ-016 SHALL hold a period register; period_load=1 writes period in any state, taking effect only at the next window start.
REQ-017 SHALL, at each window start, copy the period register (including a write in that same cycle) into an active-period register.
REQ-018 IDLE: clk_count and edge counter held at 0; enable=1 -> COUNT next cycle, that transition being a window start.
REQ-019 COUNT: clk_count increments by 1 per cycle from 0; edge counter increments on each cycle with edge_pulse=1.
REQ-020 Edge counter SHALL saturate at 127; an edge arriving at 127 sets an internal overflow flag for the window.
REQ-021 COUNT: the cycle with clk_count == active period is the last window cycle; an edge_pulse in that cycle SHALL be counted.
REQ-022 After the last window cycle SHALL enter PRESENT with result_count = final edge count, overflow = window flag, result_valid=1.
REQ-023 Window length SHALL be exactly active period + 1 cycles; active period 0 gives a 1-cycle window.
REQ-024 PRESENT: result_valid, result_count, overflow SHALL stay stable until result_valid & result_ready is sampled high.
REQ-025 On handshake: result_valid=0 next cycle; enable=1 -> COUNT (window start, counters cleared); enable=0 -> IDLE.
REQ-026 edge_pulse during PRESENT or IDLE SHALL be ignored.
REQ-027 enable=0 during COUNT SHALL abort: IDLE next cycle, counters cleared, no result produced, result outputs unchanged.
REQ-028 enable=0 during PRESENT SHALL NOT retract result_valid.
REQ-029 result_ready high while result_valid=0 SHALL have no effect.
REQ-030 state and clk_count SHALL reflect registered values with no combinational path from inputs.

Reset
REQ-031 reset low SHALL immediately force state=IDLE, clk_count=0, edge counter=0, result_valid=0, result_count=0, overflow=0, period and active-period registers=UPDATE_PERIOD.
REQ-032 Reset assertion mid-window or mid-PRESENT SHALL discard any pending result; first window after release starts no earlier than the first clk edge with enable=1.

Verification
REQ-033 UPDATE_PERIOD=9, enable=1, edge_pulse every 2nd cycle, result_ready=1 -> result_valid each 11 cycles (10 COUNT + 1 PRESENT), result_count=5, overflow=0.
REQ-034 Edge_pulse held high for a 200-cycle window (period=199) -> result_count=127, overflow=1; next window with 3 edges -> result_count=3, overflow=0.
REQ-035 result_ready=0 for 20 cycles after result_valid -> outputs stable and state=PRESENT throughout, edges ignored; ready=1 -> new window starts next cycle from clk_count=0.
REQ-036 period=4 loaded mid-window of length 10 -> current window still 10 cycles, following window 5 cycles; period=0 -> 1-cycle windows, single edge in it gives result_count=1.
REQ-037 enable dropped at clk_count=3 -> IDLE next cycle, no result_valid; reset low mid-COUNT -> all outputs at reset values asynchronously, before next clk edge.
